// File: rtl/header_decode_pkg.sv
// Shared definitions for the header decode scheduler: FSM state encoding
// and the default sizing used by the top and its arbiter.
package header_decode_pkg;

  localparam int N_CH_DEF    = 4;
  localparam int NAL_W_DEF   = 3072;
  localparam int TIMEOUT_DEF = 1024;
  localparam int TCNT_W      = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/header_decode_scheduler_rr_arbiter.sv
// Round-robin channel selector. Searches upward from the channel after
// last_grant, wrapping modulo N_CH, and reports the first requester found.
module rr_arbiter
  import header_decode_pkg::*;
#(
  parameter int  N_CH = N_CH_DEF,
  localparam int GW   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic [N_CH-1:0] req,
  input  logic [GW-1:0]   last_grant,
  output logic [GW-1:0]   grant,
  output logic            any_grant
);

  // First requester at or after last_grant+1 in circular order wins
  always_comb begin
    grant     = '0;
    any_grant = 1'b0;
    for (int k = 1; k <= N_CH; k++) begin
      automatic logic [GW-1:0] idx = GW'((int'(last_grant) + k) % N_CH);
      if (!any_grant && req[idx]) begin
        grant     = idx;
        any_grant = 1'b1;
      end
    end
  end

endmodule

// File: rtl/header_decode_scheduler.sv
// Shares one header decoder among N_CH camera requesters. A job is granted
// round-robin, the chosen NAL unit is latched and handed to the decoder,
// and the outcome (ok / error / timeout) is pulsed back to the owner.
module header_decode_scheduler
  import header_decode_pkg::*;
#(
  parameter int  N_CH    = N_CH_DEF,
  parameter int  NAL_W   = NAL_W_DEF,
  parameter int  TIMEOUT = TIMEOUT_DEF,
  localparam int GW      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [N_CH-1:0]       req,
  input  logic [N_CH*NAL_W-1:0] nal_in,
  output logic [N_CH-1:0]       resp_valid,
  output logic                  resp_ok,
  output logic                  resp_error,
  output logic                  resp_timeout,
  output logic [GW-1:0]         grant_id,
  output logic                  busy,
  output logic                  dec_start,
  output logic [NAL_W-1:0]      dec_nal,
  output logic                  dec_reset,
  input  logic                  dec_done,
  input  logic                  dec_error,
  input  logic                  dec_valid,
  output logic [TCNT_W-1:0]     timeout_cnt
);

  localparam int               CNT_W    = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e           state;
  logic [GW-1:0]    last_grant;
  logic [GW-1:0]    arb_grant;
  logic             arb_any;
  logic [NAL_W-1:0] sel_nal;
  logic [CNT_W-1:0] cyc_cnt;
  logic             ok_q;
  logic             err_q;
  logic             to_q;
  logic             dec_reset_q;

  // Saturating increment for the timed-out job counter
  function automatic logic [TCNT_W-1:0] sat_inc(input logic [TCNT_W-1:0] v);
    return (v == {TCNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  rr_arbiter #(
    .N_CH (N_CH)
  ) u_arb (
    .req        (req),
    .last_grant (last_grant),
    .grant      (arb_grant),
    .any_grant  (arb_any)
  );

  // Pick the NAL slice of the channel the arbiter is about to grant
  always_comb begin
    sel_nal = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (arb_grant == GW'(i)) sel_nal = nal_in[i*NAL_W +: NAL_W];
    end
  end

  // Job sequencing: grant, start decoder, wait for done or timeout, respond
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      last_grant  <= GW'(N_CH - 1);
      grant_id    <= '0;
      dec_nal     <= '0;
      cyc_cnt     <= '0;
      timeout_cnt <= '0;
      ok_q        <= 1'b0;
      err_q       <= 1'b0;
      to_q        <= 1'b0;
      dec_reset_q <= 1'b0;
    end else begin
      dec_reset_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (arb_any) begin
            grant_id <= arb_grant;
            dec_nal  <= sel_nal;
            state    <= ST_START;
          end
        end
        ST_START: begin
          cyc_cnt <= '0;
          state   <= ST_WAIT;
        end
        ST_WAIT: begin
          cyc_cnt <= cyc_cnt + 1'b1;
          // A completion on the final allowed cycle still counts as done
          if (dec_done) begin
            ok_q  <= dec_valid & ~dec_error;
            err_q <= dec_error;
            to_q  <= 1'b0;
            state <= ST_RESP;
          end else if (cyc_cnt == CNT_LAST) begin
            ok_q        <= 1'b0;
            err_q       <= 1'b1;
            to_q        <= 1'b1;
            dec_reset_q <= 1'b1;
            timeout_cnt <= sat_inc(timeout_cnt);
            state       <= ST_RESP;
          end
        end
        ST_RESP: begin
          last_grant <= grant_id;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Decoder controls and the one-cycle response pulse decode from state
  always_comb begin
    busy         = (state != ST_IDLE);
    dec_start    = (state == ST_START);
    dec_reset    = dec_reset_q;
    resp_valid   = '0;
    resp_ok      = 1'b0;
    resp_error   = 1'b0;
    resp_timeout = 1'b0;
    if (state == ST_RESP) begin
      resp_valid   = N_CH'(1) << grant_id;
      resp_ok      = ok_q;
      resp_error   = err_q;
      resp_timeout = to_q;
    end
  end

endmodule

// File: tb/tb_header_decode_scheduler.sv
// Bench for header_decode_scheduler: a table of directed jobs, the
// round-robin and reset-in-flight sequences, randomized jobs against a
// behavioural model, and a long run of timeouts to reach counter saturation.
module tb_header_decode_scheduler;

  localparam int N_CH = 4;
  localparam int NW   = 64;
  localparam int TO   = 16;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [N_CH-1:0]   req;
  logic [N_CH*NW-1:0] nal_in;
  logic [N_CH-1:0]   resp_valid;
  logic              resp_ok, resp_error, resp_timeout;
  logic [1:0]        grant_id;
  logic              busy, dec_start, dec_reset;
  logic [NW-1:0]     dec_nal;
  logic              dec_done, dec_error, dec_valid;
  logic [7:0]        timeout_cnt;

  always #5 clk = ~clk;

  header_decode_scheduler #(
    .N_CH    (N_CH),
    .NAL_W   (NW),
    .TIMEOUT (TO)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req          (req),
    .nal_in       (nal_in),
    .resp_valid   (resp_valid),
    .resp_ok      (resp_ok),
    .resp_error   (resp_error),
    .resp_timeout (resp_timeout),
    .grant_id     (grant_id),
    .busy         (busy),
    .dec_start    (dec_start),
    .dec_nal      (dec_nal),
    .dec_reset    (dec_reset),
    .dec_done     (dec_done),
    .dec_error    (dec_error),
    .dec_valid    (dec_valid),
    .timeout_cnt  (timeout_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  int            last_g;
  int            tcnt_m;
  logic [NW-1:0] last_nal;

  typedef struct {
    logic [3:0] req;
    int         jdone;
    bit         v;
    bit         e;
    bit         drop;
    int         g;
    bit         ok;
    bit         err;
    bit         to;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_nal();
    for (int i = 0; i < N_CH*NW/32; i++) nal_in[i*32 +: 32] = $urandom;
  endtask

  function automatic int rr_pick(input logic [3:0] r, input int last);
    for (int k = 1; k <= N_CH; k++) begin
      if (r[(last + k) % N_CH]) return (last + k) % N_CH;
    end
    return -1;
  endfunction

  task automatic do_reset();
    reset_n   = 1'b0;
    req       = '0;
    dec_done  = 1'b0;
    dec_error = 1'b0;
    dec_valid = 1'b0;
    tick();
    tick();
    chk("rst_busy",        busy,         0);
    chk("rst_resp_valid",  resp_valid,   0);
    chk("rst_resp_ok",     resp_ok,      0);
    chk("rst_resp_error",  resp_error,   0);
    chk("rst_resp_to",     resp_timeout, 0);
    chk("rst_dec_start",   dec_start,    0);
    chk("rst_dec_reset",   dec_reset,    0);
    chk("rst_grant_id",    grant_id,     0);
    chk("rst_dec_nal",     dec_nal,      0);
    chk("rst_timeout_cnt", timeout_cnt,  0);
    reset_n  = 1'b1;
    last_g   = N_CH - 1;
    tcnt_m   = 0;
    last_nal = '0;
    tick();
    chk("idle_after_rst", busy, 0);
  endtask

  // Called during an IDLE cycle with req already set. jdone is the WAIT
  // cycle index on which done is raised; jdone >= TO means never.
  task automatic run_job(input int jdone, input bit v, input bit e, input bit drop,
                         input int g, input bit ok, input bit err, input bit to);
    logic [NW-1:0] exp_nal;
    int            last;
    exp_nal = NW'(nal_in >> (g*NW));
    tick();
    chk("start_latency",  dec_start, 1);
    chk("grant_id",       grant_id,  g);
    chk("dec_nal_latch",  dec_nal,   exp_nal);
    chk("busy_start",     busy,      1);
    chk("start_no_resp",  resp_valid, 0);
    // Decoder noise before WAIT must be ignored; nal_in may change freely
    dec_done  = 1'($urandom_range(0, 1));
    dec_error = 1'($urandom_range(0, 1));
    dec_valid = 1'($urandom_range(0, 1));
    randomize_nal();
    tick();
    last = (jdone < TO) ? jdone : TO - 1;
    for (int j = 0; j <= last; j++) begin
      chk("wait_no_resp",   resp_valid, 0);
      chk("wait_no_start",  dec_start,  0);
      chk("wait_nal_hold",  dec_nal,    exp_nal);
      dec_done  = (j == jdone);
      dec_valid = v;
      dec_error = (j == jdone) ? e : 1'($urandom_range(0, 1));
      if (drop && j == 0) req[g] = 1'b0;
      tick();
    end
    if (to) tcnt_m = (tcnt_m < 255) ? tcnt_m + 1 : 255;
    chk("resp_valid",    resp_valid,   64'd1 << g);
    chk("resp_ok",       resp_ok,      ok);
    chk("resp_error",    resp_error,   err);
    chk("resp_timeout",  resp_timeout, to);
    chk("dec_reset",     dec_reset,    to);
    chk("timeout_cnt",   timeout_cnt,  tcnt_m);
    chk("resp_nal_hold", dec_nal,      exp_nal);
    dec_done  = 1'b0;
    dec_error = 1'b0;
    req[g]    = 1'b0;
    last_g    = g;
    last_nal  = exp_nal;
    tick();
    chk("post_resp_valid", resp_valid, 0);
    chk("post_busy",       busy,       0);
    chk("post_dec_reset",  dec_reset,  0);
  endtask

  initial begin
    int exp_rr[5];
    logic [3:0] pend;
    int jd, g;
    bit v, e, to;

    reset_n   = 1'b0;
    req       = '0;
    nal_in    = '0;
    dec_done  = 1'b0;
    dec_error = 1'b0;
    dec_valid = 1'b0;

    //            req      jdone v  e  drop g  ok err to
    tbl[0] = '{4'b0100,  4,    1, 0, 0,   2, 1, 0,  0};
    tbl[1] = '{4'b0011,  0,    1, 1, 0,   0, 0, 1,  0};
    tbl[2] = '{4'b0010,  16,   1, 0, 0,   1, 0, 1,  1};
    tbl[3] = '{4'b1001,  15,   1, 0, 0,   3, 1, 0,  0};
    tbl[4] = '{4'b1001,  7,    0, 0, 0,   0, 0, 0,  0};
    tbl[5] = '{4'b1110,  2,    1, 0, 1,   1, 1, 0,  0};
    tbl[6] = '{4'b1100,  20,   1, 0, 0,   2, 0, 1,  1};
    tbl[7] = '{4'b0001,  0,    1, 1, 0,   0, 0, 1,  0};

    do_reset();

    // Directed table
    for (int i = 0; i < 8; i++) begin
      req = tbl[i].req;
      randomize_nal();
      run_job(tbl[i].jdone, tbl[i].v, tbl[i].e, tbl[i].drop,
              tbl[i].g, tbl[i].ok, tbl[i].err, tbl[i].to);
    end

    // All channels requesting: strict rotation starting at channel 0
    do_reset();
    exp_rr = '{0, 1, 2, 3, 0};
    for (int k = 0; k < 5; k++) begin
      req = 4'hF;
      randomize_nal();
      run_job(2, 1, 0, 0, exp_rr[k], 1, 0, 0);
    end

    // Reset in the middle of WAIT abandons the job silently
    req = 4'b0001;
    randomize_nal();
    tick();
    chk("inflight_start", dec_start, 1);
    tick();
    tick();
    tick();
    reset_n = 1'b0;
    req     = '0;
    tick();
    chk("inflight_rst_resp", resp_valid, 0);
    chk("inflight_rst_busy", busy,       0);
    tick();
    chk("inflight_rst_resp2", resp_valid, 0);
    reset_n  = 1'b1;
    last_g   = N_CH - 1;
    tcnt_m   = 0;
    last_nal = '0;
    tick();
    chk("inflight_idle", busy, 0);
    req = 4'b0010;
    randomize_nal();
    run_job(1, 1, 0, 0, 1, 1, 0, 0);

    // Randomized jobs against the model
    pend = '0;
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        req = '0;
        for (int c = 0; c < int'($urandom_range(1, 3)); c++) begin
          randomize_nal();
          tick();
          chk("idle_busy",     busy,      0);
          chk("idle_start",    dec_start, 0);
          chk("idle_grant",    grant_id,  last_g);
          chk("idle_nal_hold", dec_nal,   last_nal);
        end
      end
      pend = pend | 4'($urandom_range(0, 15));
      if (pend == 4'b0) pend = 4'b1 << $urandom_range(0, 3);
      req = pend;
      randomize_nal();
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: jd = $urandom_range(0, TO - 1);
        6, 7:             jd = TO - 1;
        default:          jd = TO + $urandom_range(0, 3);
      endcase
      v  = 1'($urandom_range(0, 1));
      e  = 1'($urandom_range(0, 1));
      g  = rr_pick(pend, last_g);
      to = (jd >= TO);
      run_job(jd, v, e, 1'($urandom_range(0, 1)), g, !to && v && !e, to || e, to);
      pend = req;
    end

    // Long run of timeouts: counter must stick at 255
    for (int n = 0; n < 300; n++) begin
      req = 4'b1 << (n % N_CH);
      randomize_nal();
      g = rr_pick(req, last_g);
      run_job(TO + 5, 1, 0, 0, g, 0, 1, 1);
    end
    chk("timeout_cnt_sat", timeout_cnt, 255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/header_decode_scheduler.md
HEADER_DECODE_SCHEDULER -- requirements
Module: header_decode_scheduler

Interface
REQ-001 Parameters SHALL be: N_CH, default 4, number of camera requesters; NAL_W, default 3072, NAL unit width; TIMEOUT, default 1024, max decoder cycles per job.
REQ-002 Ports SHALL be: clk  in  1  sole clock, rising edge.
REQ-003 reset_n  in  1  reset, synchronous to clk, active-low.
REQ-004 req  in  N_CH  per-channel decode request, level, held until own resp_valid.
REQ-005 nal_in  in  N_CH*NAL_W  per-channel NAL unit; channel i occupies bits [i*NAL_W +: NAL_W].
REQ-006 resp_valid  out  N_CH  one-cycle completion pulse to the granted channel.
REQ-007 resp_ok / resp_error / resp_timeout  out  1 each  outcome, meaningful only while any resp_valid bit is high.
REQ-008 grant_id  out  $clog2(N_CH)  channel currently owning the decoder; busy  out  1  high in any state except IDLE.
REQ-009 dec_start  out  1; dec_nal  out  NAL_W; dec_reset  out  1  drive the shared header decoder.
REQ-010 dec_done / dec_error / dec_valid  in  1 each  decoder status.
REQ-011 timeout_cnt  out  8  saturating count of timed-out jobs since reset.

Function
REQ-012 The FSM SHALL have states IDLE, START, WAIT, RESP.
REQ-013 IDLE, any req bit high: select a channel round-robin, starting at last_grant+1 and wrapping modulo N_CH. Same edge: latch grant_id and nal_in slice into dec_nal; go to START.
REQ-014 IDLE, req all zero: stay in IDLE; dec_nal, grant_id and outputs hold.
REQ-015 START: dec_start=1 for exactly this cycle; clear the cycle counter; go to WAIT.
REQ-016 WAIT, dec_done=1: capture ok=dec_valid&~dec_error, error=dec_error, timeout=0; go to RESP.
REQ-017 WAIT, counter==TIMEOUT-1 with dec_done=0: capture ok=0, error=1, timeout=1; dec_reset=1 for one cycle; timeout_cnt+1, saturating at 255; go to RESP.
REQ-018 WAIT, dec_done=1 in the same cycle the timeout expires: dec_done SHALL win; no timeout is recorded.
REQ-019 RESP: resp_valid[grant_id]=1 with the captured flags for exactly one cycle; last_grant<=grant_id; go to IDLE.
REQ-020 Latency SHALL be 1 cycle from a req seen in IDLE to dec_start, and 1 cycle from dec_done to resp_valid. Back-to-back jobs SHALL have minimum start-to-start spacing of 4 cycles.
REQ-021 A req deasserted after grant SHALL NOT abort the job; the response is still pulsed.
REQ-022 dec_done or dec_error outside WAIT SHALL be ignored.
REQ-023 A requester SHALL drop req on the edge that registers its resp_valid, so IDLE does not regrant it spuriously.
REQ-024 With all channels requesting continuously, the grant order SHALL be 0,1,2,3,0,...; a request SHALL wait at most N_CH-1 jobs.
REQ-025 dec_nal SHALL stay stable from START until the state returns to IDLE.

Reset
REQ-026 When reset_n=0 at a clk edge: state=IDLE, last_grant=N_CH-1 (so channel 0 wins first), grant_id=0, dec_nal=0, counter=0, timeout_cnt=0.
REQ-027 During reset: resp_valid=0, resp_ok=0, resp_error=0, resp_timeout=0, dec_start=0, dec_reset=0, busy=0.
REQ-028 Reset mid-job SHALL abandon the job with no response pulse; the decoder is reset by its own reset.

Structure
REQ-029 The state enum and the default N_CH/NAL_W/TIMEOUT values SHALL live in a shared package, header_decode_pkg.
REQ-030 The round-robin selection SHALL be one sub-module, rr_arbiter (inputs req and last_grant, outputs grant index and any-grant flag), purely combinational.
REQ-031 All other logic SHALL be in the top; no logic on the clk path.

Verification
REQ-032 Reset, then req=4'b0100 and decoder done after 5 cycles with valid=1 -> dec_start 1 cycle after req; dec_nal=channel 2 slice; resp_valid=4'b0100 with resp_ok=1 one cycle after done.
REQ-033 req=4'b1111 held, each job re-raised after response -> grants 0,1,2,3,0; resp_valid never has more than one bit set.
REQ-034 Decoder never asserts done, TIMEOUT=16 -> dec_reset pulse and resp_timeout=1, resp_error=1 on the 17th cycle after dec_start; timeout_cnt=1.
REQ-035 dec_done arrives on the exact timeout cycle -> resp_timeout=0; timeout_cnt unchanged.
REQ-036 dec_error=1 with done -> resp_error=1, resp_ok=0. Separately, reset_n=0 during WAIT -> no resp_valid pulse; busy=0 the next cycle.
REQ-037 300 consecutive timeouts -> timeout_cnt saturates at 255.
